// File: rtl/tinyproc_run_ctrl_if.sv
// Host command port of the tinyproc run/debug controller.
//   cmd_valid  host -> ctrl  command present
//   cmd_ready  ctrl -> host  command taken when cmd_valid && cmd_ready at posedge
//   cmd_op     host -> ctrl  0 NOP,1 LOAD_ADDR,2 LOAD_WORD,3 RUN,4 STEP,5 HALT,6 SET_BP,7 RESET_CPU
//   cmd_data   host -> ctrl  address in [ADDR_W-1:0] or a full instruction word
//   cmd_err    ctrl -> host  one-cycle pulse: the taken command was illegal in that state
// master = host/loader side, slave = controller side.
interface tinyproc_run_ctrl_if #(
  parameter int INSTR_W = 10
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [INSTR_W-1:0] cmd_data;
  logic               cmd_err;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready, cmd_err);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready, cmd_err);
endinterface

// File: rtl/tinyproc_run_ctrl.sv
// Run/debug controller for the 8-bit accumulator core. Loads program memory
// from host commands, gates the core clock enable (halt / run / single step),
// pulses the core reset and counts executed cycles (saturating).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   cmd                   host command port (tinyproc_run_ctrl_if.slave)
//   pm_we/pm_addr/pm_wdata program memory write port (registered)
//   cpu_ip                core's next-to-execute address
//   cpu_en                core clock enable (combinational from state/breakpoint)
//   cpu_rst_n             core reset, active low (registered)
//   state                 0 HALT, 1 RUN, 2 STEP, 3 RESET
//   bp_hit                sticky: last entry to HALT was caused by the breakpoint
//   cycles                saturating count of cycles with cpu_en=1
// Build option: define TINYPROC_BREAKPOINT_EN to add the single address
// breakpoint; without it SET_BP is rejected with cmd_err and bp_hit stays 0.
module tinyproc_run_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 10,
  parameter int CYC_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  tinyproc_run_ctrl_if.slave  cmd,
  output logic                pm_we,
  output logic [ADDR_W-1:0]   pm_addr,
  output logic [INSTR_W-1:0]  pm_wdata,
  input  logic [ADDR_W-1:0]   cpu_ip,
  output logic                cpu_en,
  output logic                cpu_rst_n,
  output logic [1:0]          state,
  output logic                bp_hit,
  output logic [CYC_W-1:0]    cycles
);

  localparam logic [2:0] OP_LOAD_ADDR = 3'd1;
  localparam logic [2:0] OP_LOAD_WORD = 3'd2;
  localparam logic [2:0] OP_RUN       = 3'd3;
  localparam logic [2:0] OP_STEP      = 3'd4;
  localparam logic [2:0] OP_HALT      = 3'd5;
  localparam logic [2:0] OP_SET_BP    = 3'd6;
  localparam logic [2:0] OP_RESET_CPU = 3'd7;

  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cmd_err_q, cmd_err_d;
  logic               pm_we_q, pm_we_d;
  logic [ADDR_W-1:0]  pm_addr_q, pm_addr_d;
  logic [INSTR_W-1:0] pm_wdata_q, pm_wdata_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               bp_hit_q, bp_hit_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic               acc;
  logic               bp_stop;

`ifdef TINYPROC_BREAKPOINT_EN
  logic               bp_valid_q, bp_valid_d;
  logic [ADDR_W-1:0]  bp_addr_q, bp_addr_d;
  logic               first_run_q, first_run_d;
`else
  logic               unused_cpu_ip;
  assign unused_cpu_ip = ^cpu_ip;
`endif

  always_comb begin
    bp_stop = 1'b0;
`ifdef TINYPROC_BREAKPOINT_EN
    // The first RUN cycle skips the compare so RUN can leave a breakpoint address.
    bp_stop = (state_q == ST_RUN) && bp_valid_q && !first_run_q && (cpu_ip == bp_addr_q);
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
`endif
    cpu_en = (state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_stop);
    acc    = cmd.cmd_valid && cmd_ready_q;

    state_d    = state_q;
    cmd_err_d  = 1'b0;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;
    ptr_d      = ptr_q;
    bp_hit_d   = bp_hit_q;
    rst_cnt_d  = rst_cnt_q;
    cycles_d   = cpu_en ? sat_inc(cycles_q) : cycles_q;

    case (state_q)
      ST_HALT: begin
        if (acc) begin
          case (cmd.cmd_op)
            OP_LOAD_ADDR: ptr_d = cmd.cmd_data[ADDR_W-1:0];
            OP_LOAD_WORD: begin
              pm_we_d    = 1'b1;
              pm_addr_d  = ptr_q;
              pm_wdata_d = cmd.cmd_data;
              ptr_d      = ptr_q + 1'b1;
            end
            OP_RUN: begin
              state_d  = ST_RUN;
              bp_hit_d = 1'b0;
            end
            OP_STEP: begin
              state_d  = ST_STEP;
              bp_hit_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (bp_stop) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end
        if (acc) begin
          case (cmd.cmd_op)
            OP_LOAD_ADDR, OP_LOAD_WORD, OP_STEP: cmd_err_d = 1'b1;
            OP_HALT: state_d = ST_HALT;
            default: ;
          endcase
        end
      end
      ST_STEP: state_d = ST_HALT;
      ST_RESET: begin
        if (rst_cnt_q == '0) state_d = ST_HALT;
        else                 rst_cnt_d = rst_cnt_q - 1'b1;
      end
      default: state_d = ST_HALT;
    endcase

    // SET_BP and RESET_CPU behave the same in both accepting states.
    if (acc && (cmd.cmd_op == OP_SET_BP)) begin
`ifdef TINYPROC_BREAKPOINT_EN
      bp_valid_d = 1'b1;
      bp_addr_d  = cmd.cmd_data[ADDR_W-1:0];
`else
      cmd_err_d  = 1'b1;
`endif
    end
    if (acc && (cmd.cmd_op == OP_RESET_CPU)) begin
      state_d   = ST_RESET;
      rst_cnt_d = RC_W'(RST_CYC - 1);
      cycles_d  = '0;
      bp_hit_d  = 1'b0;
    end

`ifdef TINYPROC_BREAKPOINT_EN
    first_run_d = (state_d == ST_RUN) && (state_q != ST_RUN);
`endif
    // Ready and core reset are registered from the next state so they line up with it.
    cmd_ready_d = (state_d == ST_HALT) || (state_d == ST_RUN);
    cpu_rst_n_d = (state_d != ST_RESET);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_HALT;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      pm_we_q     <= 1'b0;
      pm_addr_q   <= '0;
      pm_wdata_q  <= '0;
      ptr_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      cycles_q    <= '0;
      rst_cnt_q   <= '0;
`ifdef TINYPROC_BREAKPOINT_EN
      bp_valid_q  <= 1'b0;
      bp_addr_q   <= '0;
      first_run_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      pm_we_q     <= pm_we_d;
      pm_addr_q   <= pm_addr_d;
      pm_wdata_q  <= pm_wdata_d;
      ptr_q       <= ptr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      bp_hit_q    <= bp_hit_d;
      cycles_q    <= cycles_d;
      rst_cnt_q   <= rst_cnt_d;
`ifdef TINYPROC_BREAKPOINT_EN
      bp_valid_q  <= bp_valid_d;
      bp_addr_q   <= bp_addr_d;
      first_run_q <= first_run_d;
`endif
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.cmd_err   = cmd_err_q;
  assign pm_we         = pm_we_q;
  assign pm_addr       = pm_addr_q;
  assign pm_wdata      = pm_wdata_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign state         = state_q;
  assign bp_hit        = bp_hit_q;
  assign cycles        = cycles_q;

endmodule

// File: tb/tb_tinyproc_run_ctrl.sv
// Bench for tinyproc_run_ctrl: command table, hand sequences and a random
// command stream compared against a reference model of the controller.
module tb_tinyproc_run_ctrl;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 10;
  localparam int CYC_W   = 6;
  localparam int RST_CYC = 2;
  localparam int CYC_MAX = (1 << CYC_W) - 1;
`ifdef TINYPROC_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif
  localparam logic [2:0] OP_NOP = 3'd0, OP_LA = 3'd1, OP_LW = 3'd2, OP_RUN = 3'd3;
  localparam logic [2:0] OP_STEP = 3'd4, OP_HALT = 3'd5, OP_SBP = 3'd6, OP_RST = 3'd7;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                pm_we;
  logic [ADDR_W-1:0]   pm_addr;
  logic [INSTR_W-1:0]  pm_wdata;
  logic [ADDR_W-1:0]   cpu_ip = '0;
  logic                cpu_en;
  logic                cpu_rst_n;
  logic [1:0]          state;
  logic                bp_hit;
  logic [CYC_W-1:0]    cycles;

  tinyproc_run_ctrl_if #(.INSTR_W(INSTR_W)) cmd ();

  tinyproc_run_ctrl #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CYC_W(CYC_W), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd.slave),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_ip(cpu_ip), .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n),
    .state(state), .bp_hit(bp_hit), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Stand-in core: ip advances on every enabled cycle, cleared by core reset.
  always @(posedge clk) begin
    if (!cpu_rst_n)   cpu_ip <= '0;
    else if (cpu_en)  cpu_ip <= cpu_ip + 8'd1;
  end

  int en_cnt = 0, we_cnt = 0, rstlow_cnt = 0;
  always @(negedge clk) begin
    if (cpu_en === 1'b1)     en_cnt     <= en_cnt + 1;
    if (pm_we === 1'b1)      we_cnt     <= we_cnt + 1;
    if (cpu_rst_n === 1'b0)  rstlow_cnt <= rstlow_cnt + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for ready, return just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [INSTR_W-1:0] data);
    int w;
    w = 0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_data  = data;
    while (cmd.cmd_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready=%0b, expected 1", cmd.cmd_ready);
    end
    tick();
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = OP_NOP;
    cmd.cmd_data  = '0;
  endtask

  typedef struct {
    logic [2:0]          op;
    logic [INSTR_W-1:0]  data;
    logic                err;
    logic [1:0]          st;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [INSTR_W-1:0]  wdata;
  } vec_t;

  vec_t tbl[17];

  // Reference model state
  int m_st, m_ptr, m_cyc, m_left, m_bpa;
  bit m_ready, m_first, m_bpv, m_bphit;

  initial begin
    int e0, c0, r0, w0, w;
    bit v, acc, hit, exp_en, e_err, e_we, first_n;
    int nxt, e_addr, e_wd;
    logic [2:0] op;
    logic [INSTR_W-1:0] data;

    tbl[0]  = '{OP_LA,   10'h010, 1'b0, 2'd0, 1'b0, 8'h00, 10'h000};
    tbl[1]  = '{OP_LW,   10'h2AA, 1'b0, 2'd0, 1'b1, 8'h10, 10'h2AA};
    tbl[2]  = '{OP_LW,   10'h155, 1'b0, 2'd0, 1'b1, 8'h11, 10'h155};
    tbl[3]  = '{OP_LA,   10'h0FF, 1'b0, 2'd0, 1'b0, 8'h00, 10'h000};
    tbl[4]  = '{OP_LW,   10'h3C3, 1'b0, 2'd0, 1'b1, 8'hFF, 10'h3C3};
    tbl[5]  = '{OP_LW,   10'h001, 1'b0, 2'd0, 1'b1, 8'h00, 10'h001};
    tbl[6]  = '{OP_NOP,  10'h000, 1'b0, 2'd0, 1'b0, 8'h00, 10'h000};
    tbl[7]  = '{OP_HALT, 10'h000, 1'b0, 2'd0, 1'b0, 8'h00, 10'h000};
    tbl[8]  = '{OP_RUN,  10'h000, 1'b0, 2'd1, 1'b0, 8'h00, 10'h000};
    tbl[9]  = '{OP_LW,   10'h123, 1'b1, 2'd1, 1'b0, 8'h00, 10'h000};
    tbl[10] = '{OP_LA,   10'h040, 1'b1, 2'd1, 1'b0, 8'h00, 10'h000};
    tbl[11] = '{OP_STEP, 10'h000, 1'b1, 2'd1, 1'b0, 8'h00, 10'h000};
    tbl[12] = '{OP_NOP,  10'h000, 1'b0, 2'd1, 1'b0, 8'h00, 10'h000};
    tbl[13] = '{OP_RUN,  10'h000, 1'b0, 2'd1, 1'b0, 8'h00, 10'h000};
    tbl[14] = '{OP_HALT, 10'h000, 1'b0, 2'd0, 1'b0, 8'h00, 10'h000};
    tbl[15] = '{OP_SBP,  10'h0F0, !BP_EN, 2'd0, 1'b0, 8'h00, 10'h000};
    tbl[16] = '{OP_LW,   10'h0AB, 1'b0, 2'd0, 1'b1, 8'h01, 10'h0AB};

    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = OP_NOP;
    cmd.cmd_data  = '0;
    reset_n       = 1'b0;
    repeat (3) tick();

    chk("rst_state", state, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_pm_we", pm_we, 0);
    chk("rst_pm_addr", pm_addr, 0);
    chk("rst_pm_wdata", pm_wdata, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_cmd_err", cmd.cmd_err, 0);
    chk("rst_cmd_ready", cmd.cmd_ready, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", cmd.cmd_ready, 1);
    chk("post_rst_cpu_rst_n", cpu_rst_n, 1);
    chk("post_rst_state", state, 0);

    for (int i = 0; i < 17; i++) begin
      send(tbl[i].op, tbl[i].data);
      chk($sformatf("tbl%0d_err", i), cmd.cmd_err, tbl[i].err);
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_pm_we", i), pm_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_pm_addr", i), pm_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_pm_wdata", i), pm_wdata, tbl[i].wdata);
      end
    end
    tick();
    chk("tbl_we_pulses", we_cnt, 5);
    chk("tbl_we_low", pm_we, 0);
    chk("tbl_bp_hit", bp_hit, 0);

    // RESET_CPU while running
    send(OP_RUN, '0);
    repeat (4) tick();
    chk("rr_running", state, 1);
    chk("rr_cpu_en", cpu_en, 1);
    r0 = rstlow_cnt;
    send(OP_RST, '0);
    chk("rr_state", state, 3);
    chk("rr_cpu_rst_n", cpu_rst_n, 0);
    chk("rr_cycles", cycles, 0);
    chk("rr_ready", cmd.cmd_ready, 0);
    chk("rr_cpu_en", cpu_en, 0);
    tick();
    chk("rr_state2", state, 3);
    tick();
    chk("rr_state_halt", state, 0);
    chk("rr_cpu_rst_n_hi", cpu_rst_n, 1);
    chk("rr_ready_hi", cmd.cmd_ready, 1);
    chk("rr_low_cycles", rstlow_cnt - r0, 2);

    // RUN for 20 cycles then HALT
    e0 = en_cnt;
    send(OP_RUN, '0);
    repeat (19) tick();
    send(OP_HALT, '0);
    chk("run20_cycles", cycles, 20);
    chk("run20_en_cnt", en_cnt - e0, 20);
    chk("run20_state", state, 0);
    chk("run20_cpu_en", cpu_en, 0);

    // Three single steps
    c0 = cycles;
    e0 = en_cnt;
    for (int i = 0; i < 3; i++) begin
      send(OP_STEP, '0);
      chk("step_state", state, 2);
      chk("step_ready", cmd.cmd_ready, 0);
      chk("step_cpu_en", cpu_en, 1);
      tick();
      chk("step_back_halt", state, 0);
      chk("step_en_off", cpu_en, 0);
      chk("step_ready_back", cmd.cmd_ready, 1);
    end
    chk("step_cycles", cycles, c0 + 3);
    chk("step_en_cnt", en_cnt - e0, 3);

    // Counter saturation
    send(OP_RST, '0);
    repeat (2) tick();
    send(OP_RUN, '0);
    repeat (79) tick();
    send(OP_HALT, '0);
    chk("sat_cycles", cycles, CYC_MAX);

`ifdef TINYPROC_BREAKPOINT_EN
    send(OP_RST, '0);
    repeat (2) tick();
    send(OP_SBP, 10'h005);
    chk("bp_set_err", cmd.cmd_err, 0);
    send(OP_RUN, '0);
    w = 0;
    while (state !== 2'd0 && w < 50) begin
      tick();
      w++;
    end
    chk("bp_halt_in_time", (w < 50), 1);
    chk("bp_hit", bp_hit, 1);
    chk("bp_ip", cpu_ip, 5);
    chk("bp_cycles", cycles, 5);
    send(OP_RUN, '0);
    chk("bp_hit_cleared", bp_hit, 0);
    repeat (3) tick();
    chk("bp_resume_ip", cpu_ip, 8);
    chk("bp_resume_state", state, 1);
    send(OP_HALT, '0);
`else
    send(OP_SBP, 10'h005);
    chk("nobp_err", cmd.cmd_err, 1);
    chk("nobp_hit", bp_hit, 0);
`endif

    // reset_n asserted while a LOAD_WORD is being presented
    send(OP_LA, 10'h033);
    w0 = we_cnt;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = OP_LW;
    cmd.cmd_data  = 10'h3FF;
    reset_n       = 1'b0;
    tick();
    cmd.cmd_valid = 1'b0;
    chk("rlw_pm_we", pm_we, 0);
    chk("rlw_pm_addr", pm_addr, 0);
    chk("rlw_pm_wdata", pm_wdata, 0);
    chk("rlw_state", state, 0);
    chk("rlw_ready", cmd.cmd_ready, 0);
    chk("rlw_cpu_rst_n", cpu_rst_n, 0);
    chk("rlw_cycles", cycles, 0);
    chk("rlw_bp_hit", bp_hit, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rlw_no_write", we_cnt - w0, 0);
    chk("rlw_ready_back", cmd.cmd_ready, 1);

    // Random command stream against the reference model
    m_st = 0; m_ptr = 0; m_cyc = 0; m_left = 0; m_bpa = 0;
    m_ready = 1; m_first = 0; m_bpv = 0; m_bphit = 0;
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 2) == 0);
      op   = 3'($urandom_range(0, 7));
      data = 10'($urandom_range(0, 1023));
      if (op == OP_SBP) data = {2'b00, cpu_ip + 8'($urandom_range(1, 6))};
      cmd.cmd_valid = v;
      cmd.cmd_op    = op;
      cmd.cmd_data  = data;

      acc    = v && m_ready;
      hit    = BP_EN && (m_st == 1) && m_bpv && !m_first && (int'(cpu_ip) == m_bpa);
      exp_en = (m_st == 2) || ((m_st == 1) && !hit);
      chk("rnd_cpu_en", cpu_en, exp_en);

      e_err = 0; e_we = 0; e_addr = 0; e_wd = 0; first_n = 0; nxt = m_st;
      if (exp_en && m_cyc < CYC_MAX) m_cyc++;
      case (m_st)
        0: if (acc) begin
          if (op == OP_LA) m_ptr = int'(data[7:0]);
          if (op == OP_LW) begin
            e_we = 1; e_addr = m_ptr; e_wd = int'(data);
            m_ptr = (m_ptr + 1) % 256;
          end
          if (op == OP_RUN)  begin nxt = 1; m_bphit = 0; first_n = 1; end
          if (op == OP_STEP) begin nxt = 2; m_bphit = 0; end
        end
        1: begin
          if (hit) begin nxt = 0; m_bphit = 1; end
          if (acc && (op == OP_LA || op == OP_LW || op == OP_STEP)) e_err = 1;
          if (acc && op == OP_HALT) nxt = 0;
        end
        2: nxt = 0;
        default: begin
          m_left--;
          if (m_left == 0) nxt = 0;
        end
      endcase
      if (acc && op == OP_SBP) begin
        if (BP_EN) begin m_bpv = 1; m_bpa = int'(data[7:0]); end
        else e_err = 1;
      end
      if (acc && op == OP_RST) begin
        nxt = 3; m_left = RST_CYC; m_cyc = 0; m_bphit = 0;
      end
      m_first = first_n;
      m_st    = nxt;
      m_ready = (nxt <= 1);

      tick();
      chk("rnd_state", state, m_st);
      chk("rnd_err", cmd.cmd_err, e_err);
      chk("rnd_pm_we", pm_we, e_we);
      if (e_we) begin
        chk("rnd_pm_addr", pm_addr, e_addr);
        chk("rnd_pm_wdata", pm_wdata, e_wd);
      end
      chk("rnd_cycles", cycles, m_cyc);
      chk("rnd_bp_hit", bp_hit, m_bphit);
      chk("rnd_ready", cmd.cmd_ready, m_ready);
    end
    cmd.cmd_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
